// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the register-file writeback port arbiter.
// Included by every file of the arbiter slice.
package wb_pkg;

    localparam int REG_IDX_W = 4;
    localparam int NUM_REGS  = 16;
    localparam int STARVE_W  = 3;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_MEM  = 2'd2
    } wb_src_t;

    // Saturating increment of the ALU starvation counter.
    function automatic logic [STARVE_W-1:0] sat_inc(
        input logic [STARVE_W-1:0] value,
        input logic [STARVE_W-1:0] limit
    );
        logic [STARVE_W-1:0] result;
        if (value >= limit) begin
            result = limit;
        end else begin
            result = value + 3'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Writeback source handshakes plus register-file write port and hazard mask.
// slave = arbiter side, master = sources / register-file side.
interface wb_port_arbiter_if #(
    parameter int DATA_W = 32
);

    logic                          alu_valid;
    logic                          alu_ready;
    logic [wb_pkg::REG_IDX_W-1:0]  alu_rd;
    logic [DATA_W-1:0]             alu_data;

    logic                          mem_valid;
    logic                          mem_ready;
    logic [wb_pkg::REG_IDX_W-1:0]  mem_rd;
    logic [DATA_W-1:0]             mem_data;

    logic                          rf_le;
    logic [wb_pkg::REG_IDX_W-1:0]  rf_rw;
    logic [DATA_W-1:0]             rf_pw;
    logic [wb_pkg::NUM_REGS-1:0]   pend_mask;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        output alu_ready, mem_ready,
        output rf_le, rf_rw, rf_pw, pend_mask
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        input  alu_ready, mem_ready,
        input  rf_le, rf_rw, rf_pw, pend_mask
    );

endinterface

// File: rtl/wb_port_arbiter_onehot.sv
// Register index plus enable to a one-hot register mask (zero when disabled).
module wb_onehot
    import wb_pkg::*;
(
    input  logic [REG_IDX_W-1:0] i_idx,
    input  logic                 i_en,
    output logic [NUM_REGS-1:0]  o_onehot
);

    // Decode the index into a single set bit.
    always_comb begin
        o_onehot = {NUM_REGS{1'b0}};
        if (i_en) begin
            o_onehot[i_idx] = 1'b1;
        end else begin
            o_onehot = {NUM_REGS{1'b0}};
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Two-source register-file writeback arbiter: loads win, ALU force-granted after
// MAX_STARVE consecutive losses. Optional counters behind macro WB_STATS_EN.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MAX_STARVE = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    wb_port_arbiter_if.slave    bus
`ifdef WB_STATS_EN
    ,
    output logic [15:0]         stat_grants,
    output logic [15:0]         stat_conflicts
`endif
);

    localparam logic [STARVE_W-1:0] MAX_S = STARVE_W'(MAX_STARVE);

    wb_src_t                w_src;
    logic                   w_grant;
    logic [STARVE_W-1:0]    w_starve_nxt;
    logic [REG_IDX_W-1:0]   w_sel_rd;
    logic [DATA_W-1:0]      w_sel_data;
    logic [NUM_REGS-1:0]    w_mask_out;
    logic [NUM_REGS-1:0]    w_mask_alu;
    logic [NUM_REGS-1:0]    w_mask_mem;

    logic [STARVE_W-1:0]    r_starve;
    logic                   r_le;
    logic [REG_IDX_W-1:0]   r_rw;
    logic [DATA_W-1:0]      r_pw;

    // Grant selection; nothing is accepted while reset is asserted.
    always_comb begin
        w_src = SRC_NONE;
        if (!rst_n) begin
            w_src = SRC_NONE;
        end else if (bus.alu_valid && (!bus.mem_valid || (r_starve >= MAX_S))) begin
            w_src = SRC_ALU;
        end else if (bus.mem_valid) begin
            w_src = SRC_MEM;
        end else begin
            w_src = SRC_NONE;
        end
    end

    assign w_grant       = (w_src != SRC_NONE);
    assign bus.alu_ready = (w_src == SRC_ALU);
    assign bus.mem_ready = (w_src == SRC_MEM);

    // Starvation bookkeeping and write-payload mux driven by the grant.
    always_comb begin
        w_starve_nxt = {STARVE_W{1'b0}};
        w_sel_rd     = {REG_IDX_W{1'b0}};
        w_sel_data   = {DATA_W{1'b0}};
        case (w_src)
            SRC_ALU: begin
                w_starve_nxt = {STARVE_W{1'b0}};
                w_sel_rd     = bus.alu_rd;
                w_sel_data   = bus.alu_data;
            end
            SRC_MEM: begin
                // The ALU only loses when it was actually asking.
                if (bus.alu_valid) begin
                    w_starve_nxt = sat_inc(r_starve, MAX_S);
                end else begin
                    w_starve_nxt = {STARVE_W{1'b0}};
                end
                w_sel_rd   = bus.mem_rd;
                w_sel_data = bus.mem_data;
            end
            SRC_NONE: begin
                w_starve_nxt = {STARVE_W{1'b0}};
            end
            default: begin
                w_starve_nxt = {STARVE_W{1'b0}};
            end
        endcase
    end

    // Starvation counter and registered register-file write stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_starve <= {STARVE_W{1'b0}};
            r_le     <= 1'b0;
            r_rw     <= {REG_IDX_W{1'b0}};
            r_pw     <= {DATA_W{1'b0}};
        end else begin
            r_starve <= w_starve_nxt;
            r_le     <= w_grant;
            if (w_grant) begin
                r_rw <= w_sel_rd;
                r_pw <= w_sel_data;
            end
        end
    end

    assign bus.rf_le = r_le;
    assign bus.rf_rw = r_rw;
    assign bus.rf_pw = r_pw;

    wb_onehot u_mask_out (
        .i_idx    (r_rw),
        .i_en     (rst_n && r_le),
        .o_onehot (w_mask_out)
    );

    wb_onehot u_mask_alu (
        .i_idx    (bus.alu_rd),
        .i_en     (rst_n && bus.alu_valid),
        .o_onehot (w_mask_alu)
    );

    wb_onehot u_mask_mem (
        .i_idx    (bus.mem_rd),
        .i_en     (rst_n && bus.mem_valid),
        .o_onehot (w_mask_mem)
    );

    assign bus.pend_mask = w_mask_out | w_mask_alu | w_mask_mem;

`ifdef WB_STATS_EN
    logic [15:0] r_stat_grants;
    logic [15:0] r_stat_conflicts;

    // Free-running wrap-around grant and conflict counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_grants    <= 16'd0;
            r_stat_conflicts <= 16'd0;
        end else begin
            if (w_grant) begin
                r_stat_grants <= r_stat_grants + 16'd1;
            end
            if (bus.alu_valid && bus.mem_valid) begin
                r_stat_conflicts <= r_stat_conflicts + 16'd1;
            end
        end
    end

    assign stat_grants    = r_stat_grants;
    assign stat_conflicts = r_stat_conflicts;
`endif

endmodule
